// File: rtl/lif_array_sched.sv
// Time-multiplexed LIF scheduler: one shared update datapath swept across
// N_NEURONS virtual neurons, with spike events emitted over valid/ready.
module lif_array_sched #(
   parameter int N_NEURONS  = 8,
   parameter int IDX_W      = 3,
   parameter int LEAK_SHIFT = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             step,
   input  logic [7:0]       threshold,
   input  logic             cur_we,
   input  logic [IDX_W-1:0] cur_addr,
   input  logic [7:0]       cur_data,
   output logic             evt_valid,
   input  logic             evt_ready,
   output logic [IDX_W-1:0] evt_idx,
   output logic             busy,
   output logic             done,
   output logic [IDX_W:0]   spike_count,
   input  logic [IDX_W-1:0] rd_addr,
   output logic [7:0]       rd_state
);

   typedef enum logic [2:0] {IDLE, LOAD, UPDATE, WAIT_EVT, DONE} fsm_t;

   fsm_t             fsm_q, fsm_d;
   logic [7:0]       mem_state [N_NEURONS];
   logic [7:0]       mem_cur   [N_NEURONS];
   logic [7:0]       thr_q;
   logic [IDX_W-1:0] idx_q;
   logic [IDX_W:0]   cnt_q;

   logic [7:0]       st_sel, cur_sel, next_val;
   logic [8:0]       sum;
   logic             spike, advance, last, cur_ok, rd_ok;

   // Shared datapath for the neuron currently addressed by idx_q
   assign st_sel   = mem_state[idx_q];
   assign cur_sel  = mem_cur[idx_q];
   assign spike    = (st_sel >= thr_q);
   assign sum      = {1'b0, cur_sel} + ({1'b0, st_sel} >> LEAK_SHIFT);
   assign next_val = spike ? cur_sel : (sum[8] ? 8'hFF : sum[7:0]);
   assign last     = (idx_q == IDX_W'(N_NEURONS - 1));

   assign cur_ok   = ({1'b0, cur_addr} < (IDX_W+1)'(N_NEURONS));
   assign rd_ok    = ({1'b0, rd_addr} < (IDX_W+1)'(N_NEURONS));
   assign rd_state = rd_ok ? mem_state[rd_addr] : 8'd0;

   assign evt_idx  = evt_valid ? idx_q : '0;
   assign busy     = (fsm_q != IDLE);
   assign done     = (fsm_q == DONE);

   always_comb begin
      fsm_d     = fsm_q;
      evt_valid = 1'b0;
      advance   = 1'b0;
      case (fsm_q)
         IDLE:     if (step) fsm_d = LOAD;
         LOAD:     fsm_d = UPDATE;
         UPDATE: begin
            if (!spike) begin
               advance = 1'b1;
            end else begin
               evt_valid = 1'b1;
               if (evt_ready) advance = 1'b1;
               else           fsm_d   = WAIT_EVT;
            end
         end
         WAIT_EVT: begin
            evt_valid = 1'b1;
            if (evt_ready) advance = 1'b1;
         end
         DONE:     fsm_d = IDLE;
         default:  fsm_d = IDLE;
      endcase
      // A completed neuron (plain update or accepted event) moves the sweep on
      if (advance) fsm_d = last ? DONE : UPDATE;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         fsm_q       <= IDLE;
         thr_q       <= '0;
         idx_q       <= '0;
         cnt_q       <= '0;
         spike_count <= '0;
         for (int i = 0; i < N_NEURONS; i++) begin
            mem_state[i] <= '0;
            mem_cur[i]   <= '0;
         end
      end else begin
         fsm_q <= fsm_d;
         case (fsm_q)
            LOAD: begin
               thr_q <= threshold;
               idx_q <= '0;
               cnt_q <= '0;
            end
            DONE:    spike_count <= cnt_q;
            default: ;
         endcase
         if (advance) begin
            mem_state[idx_q] <= next_val;
            if (spike) cnt_q <= cnt_q + 1'b1;
            if (!last) idx_q <= idx_q + 1'b1;
         end
         // Currents only change between sweeps so each sweep sees one snapshot
         if (fsm_q == IDLE && cur_we && cur_ok) mem_cur[cur_addr] <= cur_data;
      end
   end

endmodule

// File: tb/tb_lif_array_sched.sv
// Self-checking bench for lif_array_sched: directed scenarios plus randomized
// sweeps compared against a per-neuron behavioural model.
module tb_lif_array_sched;

   localparam int N  = 8;
   localparam int IW = 3;
   localparam int LS = 1;

   localparam int IF_ST   [4] = '{100, 150, 100, 150};
   localparam int IF_CNT  [4] = '{0, 0, 1, 0};
   localparam int SAT_ST  [3] = '{200, 255, 200};
   localparam int SAT_CNT [3] = '{0, 0, 1};
   localparam int LEAK_ST [4] = '{10, 12, 13, 13};

   logic          clk, rst_n, step, cur_we, evt_ready;
   logic [7:0]    threshold, cur_data;
   logic [IW-1:0] cur_addr, rd_addr;
   logic          evt_valid, busy, done;
   logic [IW-1:0] evt_idx;
   logic [IW:0]   spike_count;
   logic [7:0]    rd_state;
   logic          evt_valid2, busy2, done2;
   logic [IW-1:0] evt_idx2;
   logic [IW:0]   spike_count2;
   logic [7:0]    rd_state2;

   int checkCount = 0;
   int passCount  = 0;
   int failCount  = 0;
   int refState [N];
   int refCur   [N];
   int expEvents [$];
   int leakEvt;

   lif_array_sched #(.N_NEURONS(N), .IDX_W(IW), .LEAK_SHIFT(LS)) u_dut (
      .clk(clk), .rst_n(rst_n), .step(step), .threshold(threshold),
      .cur_we(cur_we), .cur_addr(cur_addr), .cur_data(cur_data),
      .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_idx(evt_idx),
      .busy(busy), .done(done), .spike_count(spike_count),
      .rd_addr(rd_addr), .rd_state(rd_state));

   lif_array_sched #(.N_NEURONS(N), .IDX_W(IW), .LEAK_SHIFT(2)) u_leak (
      .clk(clk), .rst_n(rst_n), .step(step), .threshold(threshold),
      .cur_we(cur_we), .cur_addr(cur_addr), .cur_data(cur_data),
      .evt_valid(evt_valid2), .evt_ready(evt_ready), .evt_idx(evt_idx2),
      .busy(busy2), .done(done2), .spike_count(spike_count2),
      .rd_addr(rd_addr), .rd_state(rd_state2));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checkCount++;
      assert (obs === exp) passCount++;
      else begin
         failCount++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // One timestep of every neuron, straight from the LIF rules
   function automatic void modelSweep(input int thr);
      expEvents.delete();
      for (int i = 0; i < N; i++) begin
         if (refState[i] >= thr) begin
            expEvents.push_back(i);
            refState[i] = refCur[i];
         end else begin
            refState[i] = refCur[i] + refState[i] / (1 << LS);
            if (refState[i] > 255) refState[i] = 255;
         end
      end
   endfunction

   task automatic doReset();
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < N; i++) begin
         refState[i] = 0;
         refCur[i]   = 0;
      end
   endtask

   task automatic writeCur(input int addr, input int data);
      @(negedge clk);
      cur_we   = 1'b1;
      cur_addr = IW'(addr);
      cur_data = 8'(data);
      @(negedge clk);
      cur_we = 1'b0;
      refCur[addr] = data;
   endtask

   task automatic readState(input int addr, output logic [7:0] v, output logic [7:0] v2);
      rd_addr = IW'(addr);
      #1;
      v  = rd_state;
      v2 = rd_state2;
   endtask

   task automatic checkStates();
      for (int i = 0; i < N; i++) begin
         rd_addr = IW'(i);
         #1;
         checkOutput($sformatf("state%0d", i), rd_state, refState[i]);
      end
   endtask

   // mode 0: ready always high, 1: random ready, 2: ready low for 'stall' valid cycles
   task automatic applyStimulus(input int thr, input int mode, input int stall,
                                input bit wrEn, input int wrAddr, input int wrData,
                                input bit injectBusy);
      int k, doneK, busyCnt, stallLeft, prevIdx;
      bit prevPend;
      int got [$];
      @(negedge clk);
      step      = 1'b1;
      threshold = 8'(thr);
      cur_we    = wrEn;
      cur_addr  = IW'(wrAddr);
      cur_data  = 8'(wrData);
      evt_ready = 1'b0;
      if (wrEn) refCur[wrAddr] = wrData;
      modelSweep(thr);
      @(negedge clk);
      step      = 1'b0;
      cur_we    = 1'b0;
      k         = 1;
      doneK     = 0;
      busyCnt   = 0;
      stallLeft = stall;
      prevPend  = 1'b0;
      prevIdx   = 0;
      while (k <= 400) begin
         case (mode)
            0: evt_ready = 1'b1;
            1: evt_ready = 1'($urandom_range(0, 1));
            default: begin
               if (stallLeft > 0) begin
                  evt_ready = 1'b0;
                  if (evt_valid) stallLeft--;
               end else begin
                  evt_ready = 1'b1;
               end
            end
         endcase
         if (injectBusy && k == 3) begin
            step     = 1'b1;
            cur_we   = 1'b1;
            cur_addr = IW'(2);
            cur_data = 8'd77;
         end
         if (k == 4) begin
            step   = 1'b0;
            cur_we = 1'b0;
         end
         if (busy) busyCnt++;
         if (evt_valid2) leakEvt++;
         if (prevPend) begin
            checkOutput("hold_valid", evt_valid, 1);
            checkOutput("hold_idx", evt_idx, prevIdx);
         end
         if (evt_valid && evt_ready) got.push_back(int'(evt_idx));
         prevPend = evt_valid && !evt_ready;
         prevIdx  = int'(evt_idx);
         if (done) begin
            doneK = k;
            break;
         end
         @(negedge clk);
         k++;
      end
      step      = 1'b0;
      cur_we    = 1'b0;
      evt_ready = 1'b0;
      checkOutput("done_seen", doneK != 0, 1);
      checkOutput("evt_total", got.size(), expEvents.size());
      for (int i = 0; i < got.size() && i < expEvents.size(); i++)
         checkOutput($sformatf("evt%0d_idx", i), got[i], expEvents[i]);
      if (mode == 0) begin
         checkOutput("done_latency", doneK, N + 2);
         checkOutput("busy_cycles", busyCnt, N + 2);
      end
      @(negedge clk);
      checkOutput("spike_count", spike_count, expEvents.size());
      checkOutput("idle_after", busy, 0);
      checkOutput("evt_idx_idle", evt_idx, 0);
      checkStates();
   endtask

   initial begin
      logic [7:0] v, v2;
      int pend;
      rst_n = 1'b0; step = 1'b0; threshold = '0; cur_we = 1'b0;
      cur_addr = '0; cur_data = '0; evt_ready = 1'b0; rd_addr = '0;
      leakEvt = 0;

      // reset state
      doReset();
      checkOutput("rst_valid", evt_valid, 0);
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_done", done, 0);
      checkOutput("rst_count", spike_count, 0);
      checkStates();

      // integrate and fire on neuron 3
      writeCur(3, 100);
      for (int s = 0; s < 4; s++) begin
         applyStimulus(150, 0, 0, 1'b0, 0, 0, 1'b0);
         readState(3, v, v2);
         checkOutput($sformatf("if_state_%0d", s), v, IF_ST[s]);
         checkOutput($sformatf("if_count_%0d", s), spike_count, IF_CNT[s]);
      end

      // saturation on neuron 0
      doReset();
      writeCur(0, 200);
      for (int s = 0; s < 3; s++) begin
         applyStimulus(255, 0, 0, 1'b0, 0, 0, 1'b0);
         readState(0, v, v2);
         checkOutput($sformatf("sat_state_%0d", s), v, SAT_ST[s]);
         checkOutput($sformatf("sat_count_%0d", s), spike_count, SAT_CNT[s]);
      end

      // backpressure with every neuron spiking
      doReset();
      for (int i = 0; i < N; i++) writeCur(i, 1);
      applyStimulus(0, 2, 5, 1'b0, 0, 0, 1'b0);
      checkOutput("bp_count", spike_count, N);

      // ignored inputs while busy, same-cycle write with step
      doReset();
      for (int i = 0; i < N; i++) writeCur(i, i * 3);
      applyStimulus(255, 0, 0, 1'b1, 6, 50, 1'b1);
      readState(6, v, v2);
      checkOutput("wr_with_step", v, 50);
      applyStimulus(255, 0, 0, 1'b0, 0, 0, 1'b0);
      readState(2, v, v2);
      checkOutput("busy_write_ignored", v, 9);

      // leak shift of 2 on the second instance
      doReset();
      writeCur(5, 10);
      leakEvt = 0;
      for (int s = 0; s < 4; s++) begin
         applyStimulus(255, 0, 0, 1'b0, 0, 0, 1'b0);
         readState(5, v, v2);
         checkOutput($sformatf("leak_state_%0d", s), v2, LEAK_ST[s]);
      end
      checkOutput("leak_events", leakEvt, 0);
      checkOutput("leak_count", spike_count2, 0);
      checkOutput("leak_idle", busy2, 0);
      checkOutput("leak_done", done2, 0);
      checkOutput("leak_idx", evt_idx2, 0);

      // reset in the middle of a sweep with an event pending
      @(negedge clk);
      step      = 1'b1;
      threshold = 8'd0;
      evt_ready = 1'b0;
      @(negedge clk);
      step = 1'b0;
      pend = 0;
      for (int c = 0; c < 10 && pend == 0; c++) begin
         if (evt_valid) pend = 1;
         else @(negedge clk);
      end
      checkOutput("mid_pending", pend, 1);
      rst_n = 1'b0;
      @(negedge clk);
      checkOutput("mid_valid", evt_valid, 0);
      checkOutput("mid_busy", busy, 0);
      checkOutput("mid_count", spike_count, 0);
      rst_n = 1'b1;
      for (int i = 0; i < N; i++) begin
         refState[i] = 0;
         refCur[i]   = 0;
      end
      checkStates();
      applyStimulus(0, 0, 0, 1'b0, 0, 0, 1'b0);

      // randomized sweeps with random backpressure
      for (int r = 0; r < 8; r++) begin
         writeCur($urandom_range(0, N - 1), $urandom_range(0, 255));
         writeCur($urandom_range(0, N - 1), $urandom_range(0, 255));
         applyStimulus($urandom_range(0, 255), 1, 0, 1'($urandom_range(0, 1)),
                       $urandom_range(0, N - 1), $urandom_range(0, 255), 1'b0);
      end

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
